seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 139 +++++++++++++
 tb/tb_seq_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_DBZ_DETECT_EN to short-circuit divide-by-zero and flag it on div_by_zero.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE,
    ZERO
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH:0]   part_rem;
  logic [CW-1:0]    iter;

  logic             accept;
  logic             b_zero;
  logic             last_iter;
  logic             fits;
  logic [WIDTH+1:0] p_shift;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;

  // The extra top bit keeps the trial subtraction exact, so its sign bit is the restore decision.
  always_comb begin
    p_shift   = {part_rem, dividend[WIDTH-1]};
    diff      = p_shift - (WIDTH + 2)'(divisor);
    fits      = ~diff[WIDTH+1];
    p_next    = fits ? diff[WIDTH:0] : p_shift[WIDTH:0];
    q_next    = {quotient[WIDTH-2:0], fits};
    last_iter = (iter == CW'(WIDTH - 1));
    accept    = start && ((state == IDLE) || (state == DONE));
    b_zero    = (B == '0);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
          next_state = b_zero ? ZERO : CALC;
`else
          next_state = CALC;
`endif
        end else begin
          next_state = IDLE;
        end
      end
      CALC: begin
        if (last_iter) begin
          next_state = DONE;
        end
      end
      ZERO:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == CALC);
      done  <= (next_state == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend <= '0;
      divisor  <= '0;
      quotient <= '0;
      part_rem <= '0;
      iter     <= '0;
      Q        <= '0;
      R        <= '0;
    end else if (accept) begin
      dividend <= A;
      divisor  <= B;
      quotient <= '0;
      part_rem <= '0;
      iter     <= '0;
    end else if (state == CALC) begin
      dividend <= dividend << 1;
      quotient <= q_next;
      part_rem <= p_next;
      iter     <= iter + CW'(1);
      if (last_iter) begin
        Q <= q_next;
        R <= p_next[WIDTH-1:0];
      end
`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
    end else if (state == ZERO) begin
      Q <= '1;
      R <= dividend;
`endif
    end
  end

`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
  // The flag follows whichever completion last loaded Q/R.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_by_zero <= 1'b0;
    end else if (state == ZERO) begin
      div_by_zero <= 1'b1;
    end else if ((state == CALC) && last_iter) begin
      div_by_zero <= 1'b0;
    end
  end
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of seq_divider at WIDTH=8 plus an exhaustive WIDTH=2 sweep.
// Expected results follow SEQ_DIVIDER_DBZ_DETECT_EN when it is defined for the build.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_DBZ_DETECT_EN
  localparam bit DBZ_ON = 1'b1;
`else
  localparam bit DBZ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b, q, r;
  logic       busy, done, dbz;
  logic       start2;
  logic [1:0] a2, b2, q2, r2;
  logic       busy2, done2, dbz2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Q(q), .R(r), .div_by_zero(dbz)
  );

  seq_divider #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .Q(q2), .R(r2), .div_by_zero(dbz2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request that is sampled at the next rising edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    tick();
    start = 1'b0;
    a     = 8'hA5;
    b     = 8'h5A;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (done) pulses++;
    end
  endtask

  task automatic run_div(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                         input int elat);
    int lat, busy_cnt;
    applyStimulus(av, bv);
    checkOutput({tag, "_busy0"}, busy, (elat > 1));
    wait_done(lat, busy_cnt);
    checkOutput({tag, "_lat"}, lat, elat);
    checkOutput({tag, "_busycnt"}, busy_cnt, elat - 1);
    checkOutput({tag, "_busyoff"}, busy, 0);
    checkOutput({tag, "_q"}, q, eq);
    checkOutput({tag, "_r"}, r, er);
    checkOutput({tag, "_dbz"}, dbz, edbz);
    tick();
    checkOutput({tag, "_pulse"}, done, 0);
    checkOutput({tag, "_hold_q"}, q, eq);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, busy_cnt, pulses;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start2 = 1'b0;
    a2     = '0;
    b2     = '0;
    tick();
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_q", q, 0);
    checkOutput("rst_r", r, 0);
    checkOutput("rst_dbz", dbz, 0);
    checkOutput("rst_q2", q2, 0);
    rst = 1'b0;
    tick();

    run_div("nom", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8);
    run_div("div1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
    run_div("small", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
    run_div("zero_a", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 8);
    run_div("equal", 8'd200, 8'd200, 8'd1, 8'd0, 1'b0, 8);
    run_div("dbz", 8'd37, 8'd0, 8'd255, 8'd37, DBZ_ON, DBZ_ON ? 1 : 8);
    run_div("after_dbz", 8'd13, 8'd4, 8'd3, 8'd1, 1'b0, 8);

    // A request two cycles into a division must be dropped entirely.
    applyStimulus(8'd100, 8'd7);
    tick();
    tick();
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd3;
    tick();
    start = 1'b0;
    wait_done(lat, busy_cnt);
    checkOutput("ign_lat", lat, 5);
    checkOutput("ign_q", q, 14);
    checkOutput("ign_r", r, 2);
    count_done(15, pulses);
    checkOutput("ign_extra_done", pulses, 0);

    // Start held from mid-CALC through the DONE cycle is taken at the DONE edge.
    applyStimulus(8'd100, 8'd7);
    for (int n = 0; n < 5; n++) tick();
    start = 1'b1;
    a     = 8'd50;
    b     = 8'd6;
    wait_done(lat, busy_cnt);
    checkOutput("b2b_first_lat", lat, 3);
    checkOutput("b2b_first_q", q, 14);
    checkOutput("b2b_first_r", r, 2);
    tick();
    start = 1'b0;
    checkOutput("b2b_pulse", done, 0);
    checkOutput("b2b_busy", busy, 1);
    wait_done(lat, busy_cnt);
    checkOutput("b2b_gap", lat + 1, 9);
    checkOutput("b2b_q", q, 8);
    checkOutput("b2b_r", r, 2);
    tick();
    checkOutput("b2b_pulse2", done, 0);

    // Reset landing on iteration 4 aborts with no completion.
    applyStimulus(8'd255, 8'd1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_q", q, 0);
    checkOutput("abort_r", r, 0);
    rst = 1'b0;
    count_done(15, pulses);
    checkOutput("abort_no_done", pulses, 0);

    for (int av = 0; av < 4; av++) begin
      for (int bv = 0; bv < 4; bv++) begin
        int exp_q, exp_r, exp_lat, lat2;
        exp_q   = (bv == 0) ? 3 : av / bv;
        exp_r   = (bv == 0) ? av : av % bv;
        exp_lat = (bv == 0 && DBZ_ON) ? 1 : 2;
        start2 = 1'b1;
        a2     = 2'(av);
        b2     = 2'(bv);
        tick();
        start2 = 1'b0;
        lat2   = 0;
        for (int n = 1; n <= 10; n++) begin
          tick();
          if (done2) begin
            lat2 = n;
            break;
          end
        end
        checkOutput($sformatf("w2_%0d_%0d_lat", av, bv), lat2, exp_lat);
        checkOutput($sformatf("w2_%0d_%0d_q", av, bv), q2, exp_q);
        checkOutput($sformatf("w2_%0d_%0d_r", av, bv), r2, exp_r);
        checkOutput($sformatf("w2_%0d_%0d_dbz", av, bv), dbz2, (bv == 0) && DBZ_ON);
        if (bv != 0) begin
          checkOutput($sformatf("w2_%0d_%0d_ident", av, bv), int'(q2) * bv + int'(r2), av);
        end
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
